// File: rtl/uart_rx_bcd.sv
// 8N1 UART receiver that unpacks each byte into two BCD digits.
// Optional even-parity (8E1) framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_bcd #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [7:0] rx_byte,
  output logic       data_valid,
  output logic       frame_err,
  output logic       digit_err,
  output logic       busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    RECOVER
  } state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [TW-1:0] tick, tick_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          byte_ld, bcd_ld;
  logic          dv_nxt, fe_nxt, de_nxt;
  logic          digits_ok;
`ifdef UART_RX_PARITY_EN
  logic          par_err, par_err_nxt;
`endif

  assign digits_ok = (shreg[7:4] <= 4'd9) && (shreg[3:0] <= 4'd9);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick + TW'(1);
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    byte_ld   = 1'b0;
    bcd_ld    = 1'b0;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    de_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_nxt = par_err;
`endif
    unique case (state)
      IDLE: begin
        tick_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (tick == HALF_M1) begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick == FULL_M1) begin
          tick_nxt         = '0;
          sh_nxt[bit_cnt]  = rx_s;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick == FULL_M1) begin
          tick_nxt    = '0;
          par_err_nxt = rx_s ^ (^shreg);
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick == FULL_M1) begin
          tick_nxt = '0;
`ifdef UART_RX_PARITY_EN
          // A parity failure still honours the stop bit to pick IDLE vs RECOVER.
          if (par_err) begin
            fe_nxt    = 1'b1;
            state_nxt = rx_s ? IDLE : RECOVER;
          end else
`endif
          if (rx_s) begin
            byte_ld   = 1'b1;
            bcd_ld    = digits_ok;
            dv_nxt    = digits_ok;
            de_nxt    = !digits_ok;
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = RECOVER;
          end
        end
      end
      RECOVER: begin
        tick_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      bcd0       <= '0;
      bcd1       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      digit_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      rx_m       <= rx_in;
      rx_s       <= rx_m;
      state      <= state_nxt;
      tick       <= tick_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= sh_nxt;
      data_valid <= dv_nxt;
      frame_err  <= fe_nxt;
      digit_err  <= de_nxt;
      if (byte_ld) rx_byte <= shreg;
      if (bcd_ld) begin
        bcd1 <= shreg[7:4];
        bcd0 <= shreg[3:0];
      end
`ifdef UART_RX_PARITY_EN
      par_err    <= par_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_bcd.sv
// Directed bench for uart_rx_bcd: expected pulses/outputs are queued per frame
// and matched by a monitor whenever the receiver pulses.
module tb_uart_rx_bcd;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [3:0] bcd0, bcd1;
  logic [7:0] rx_byte;
  logic       data_valid, frame_err, digit_err, busy;

  uart_rx_bcd #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .bcd0(bcd0), .bcd1(bcd1), .rx_byte(rx_byte),
    .data_valid(data_valid), .frame_err(frame_err), .digit_err(digit_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 valid, 1 frame error, 2 digit error
    logic [7:0] rb;
    logic [3:0] b1;
    logic [3:0] b0;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [7:0] m_byte = '0;
  logic [3:0] m_b1 = '0, m_b0 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic par_flip);
    exp_t e;
    logic bad_frame;
    bad_frame = !stop;
`ifdef UART_RX_PARITY_EN
    bad_frame = bad_frame || par_flip;
`endif
    if (bad_frame) begin
      e.kind = 1;
    end else begin
      m_byte = b;
      if (b[7:4] <= 4'd9 && b[3:0] <= 4'd9) begin
        e.kind = 0;
        m_b1 = b[7:4];
        m_b0 = b[3:0];
      end else begin
        e.kind = 2;
      end
    end
    e.rb = m_byte;
    e.b1 = m_b1;
    e.b0 = m_b0;
    q.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ par_flip, CPB);
`endif
    hold(stop, CPB);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * CPB && q.size() != 0; i++) @(negedge clk);
    chk(tag, q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (data_valid || frame_err || digit_err) begin
      chk("pulse_onehot", $countones({data_valid, frame_err, digit_err}), 1);
      chk("pulse_expected", (q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        k = data_valid ? 0 : (frame_err ? 1 : 2);
        chk("pulse_kind", k, e.kind);
        chk("rx_byte", rx_byte, e.rb);
        chk("bcd1", bcd1, e.b1);
        chk("bcd0", bcd0, e.b0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bcd0", bcd0, 0);
    chk("rst_bcd1", bcd1, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_pulses", {data_valid, frame_err, digit_err}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    hold(1'b1, 5);

    send(8'h20, 1'b1, 1'b0);
    drain("drain_20");
    send(8'h11, 1'b1, 1'b0);
    send(8'h04, 1'b1, 1'b0);
    drain("drain_11_04");
    hold(1'b1, 10);

    // Short low glitch must abort without any pulse.
    hold(1'b0, 4);
    rx_in = 1'b1;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("glitch_busy", busy, 0);
    hold(1'b1, 10);
    chk("glitch_bcd", {bcd1, bcd0}, 8'h04);

    send(8'h35, 1'b0, 1'b0);
    hold(1'b0, 40);
    drain("drain_35");
    chk("break_busy", busy, 1);
    hold(1'b1, 5);
    chk("recover_busy", busy, 0);
    send(8'h42, 1'b1, 1'b0);
    drain("drain_42");

    send(8'h3A, 1'b1, 1'b0);
    drain("drain_3a");

    // Abort 0x99 during data bit 4 with reset.
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1 ^ (i == 1 || i == 2), CPB);
    hold(1'b1, CPB / 2);
    rst = 1'b1;
    #1;
    chk("midrst_bcd", {bcd1, bcd0}, 0);
    chk("midrst_byte", rx_byte, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulses", {data_valid, frame_err, digit_err}, 0);
    m_byte = '0; m_b1 = '0; m_b0 = '0;
    @(negedge clk);
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 3 * CPB);
    send(8'h57, 1'b1, 1'b0);
    drain("drain_57");
    chk("final_bcd", {bcd1, bcd0}, 8'h57);

`ifdef UART_RX_PARITY_EN
    send(8'h20, 1'b1, 1'b0);
    drain("drain_par_ok");
    send(8'h20, 1'b1, 1'b1);
    drain("drain_par_bad");
    chk("par_bcd_hold", {bcd1, bcd0}, 8'h20);
`endif

    hold(1'b1, 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
